// File: rtl/motor_cmd_sched.sv
// Per-frame motor command scheduler: arm/disarm FSM, per-channel slew limiting
// toward latched targets, and common-frame reload pulses for the PWM channels.
module motor_cmd_sched #(
  parameter int unsigned NUM_MOT    = 4,
  parameter int unsigned RPM_W      = 7,
  parameter int unsigned SLEW_STEP  = 4,
  parameter int unsigned ARM_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       arm_req,
  input  logic                       disarm_req,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [NUM_MOT*RPM_W-1:0]   cmd_rpm,
  output logic                       armed,
  output logic [1:0]                 state,
  output logic                       frame_start,
  output logic [NUM_MOT-1:0]         pwm_set,
  output logic [NUM_MOT*RPM_W-1:0]   pwm_rpm
);

  localparam int unsigned ACW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [RPM_W:0] STEP_W = (RPM_W+1)'(SLEW_STEP);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    STOPPING = 2'd3
  } state_t;

  state_t           st;
  logic [RPM_W-1:0] frame_cnt;
  logic [ACW-1:0]   arm_cnt;
  logic [RPM_W-1:0] tgt [NUM_MOT];
  logic [RPM_W-1:0] cur [NUM_MOT];
  logic [RPM_W-1:0] nxt [NUM_MOT];
  logic [RPM_W:0]   diff;
  logic             tick;
  logic             all_zero;

  assign tick  = &frame_cnt;
  assign state = st;

  // Slew step is clamped to the remaining distance, so no overshoot or wrap.
  always_comb begin
    all_zero = 1'b1;
    diff     = '0;
    for (int unsigned i = 0; i < NUM_MOT; i++) begin
      nxt[i] = cur[i];
      if (tgt[i] > cur[i]) begin
        diff   = {1'b0, tgt[i]} - {1'b0, cur[i]};
        nxt[i] = cur[i] + RPM_W'((diff > STEP_W) ? STEP_W : diff);
      end else if (tgt[i] < cur[i]) begin
        diff   = {1'b0, cur[i]} - {1'b0, tgt[i]};
        nxt[i] = cur[i] - RPM_W'((diff > STEP_W) ? STEP_W : diff);
      end
      if (nxt[i] != '0) all_zero = 1'b0;
    end
  end

  always_comb begin
    pwm_rpm = '0;
    for (int unsigned i = 0; i < NUM_MOT; i++)
      pwm_rpm[i*RPM_W +: RPM_W] = cur[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st          <= DISARMED;
      frame_cnt   <= '0;
      arm_cnt     <= '0;
      frame_start <= 1'b0;
      pwm_set     <= '0;
      armed       <= 1'b0;
      cmd_ready   <= 1'b0;
      for (int unsigned i = 0; i < NUM_MOT; i++) begin
        tgt[i] <= '0;
        cur[i] <= '0;
      end
    end else begin
      frame_cnt   <= frame_cnt + RPM_W'(1);
      frame_start <= tick;
      pwm_set     <= {NUM_MOT{tick}};
      if (tick) begin
        for (int unsigned i = 0; i < NUM_MOT; i++)
          cur[i] <= nxt[i];
      end

      case (st)
        DISARMED: begin
          for (int unsigned i = 0; i < NUM_MOT; i++) tgt[i] <= '0;
          if (arm_req && !disarm_req) begin
            st      <= ARMING;
            arm_cnt <= '0;
          end
        end
        ARMING: begin
          for (int unsigned i = 0; i < NUM_MOT; i++) tgt[i] <= '0;
          arm_cnt <= arm_cnt + ACW'(1);
          if (disarm_req) begin
            st <= DISARMED;
          end else if (arm_cnt == ACW'(ARM_CYCLES-1)) begin
            st        <= ARMED;
            armed     <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end
        ARMED: begin
          // Slew at a tick reads the old target; a new one takes effect next tick.
          if (disarm_req) begin
            st        <= STOPPING;
            armed     <= 1'b0;
            cmd_ready <= 1'b0;
            for (int unsigned i = 0; i < NUM_MOT; i++) tgt[i] <= '0;
          end else if (cmd_valid && cmd_ready) begin
            for (int unsigned i = 0; i < NUM_MOT; i++)
              tgt[i] <= cmd_rpm[i*RPM_W +: RPM_W];
          end
        end
        STOPPING: begin
          for (int unsigned i = 0; i < NUM_MOT; i++) tgt[i] <= '0;
          if (tick && all_zero) st <= DISARMED;
        end
        default: st <= DISARMED;
      endcase
    end
  end

endmodule
